branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
// Program-counter sequencer sitting directly downstream of the flag validator.
// Consumes its FLAGS_ARE_VALID condition result and decides each instruction's
// next PC: sequential, conditional JUMP, CALL/RET through an internal return
// stack, or HALT. Drives the fetch address to a synchronous instruction ROM and
// squashes the single wrong-path instruction after every taken redirect.
// PARAMETERS
// ADDR_W        8      PC / target width; PC arithmetic wraps modulo 2**ADDR_W
// STACK_DEPTH   8      return-stack entries (>=2)
// RESET_VECTOR  0      PC value loaded at reset
// PORTS
// CLK             in   1        system clock, rising edge
// RST_N           in   1        asynchronous active-low reset
// STALL           in   1        1 = hold all state; instruction is re-presented later
// INSTR_VALID     in   1        INSTR_* carry the instruction fetched at PC_LAST
// INSTR_KIND      in   3        0 SEQ, 1 JUMP, 2 CALL, 3 RET, 4 HALT, 5-7 treated as SEQ
// INSTR_TARGET    in   ADDR_W   JUMP/CALL destination
// FLAGS_ARE_VALID in   1        condition pass from flag validator (1 = take)
// PC              out  ADDR_W   fetch address presented to ROM
// PC_VALID        out  1        PC is a real fetch request this cycle
// REDIRECT        out  1        one-cycle pulse: taken JUMP/CALL/RET, flush downstream
// STACK_LEVEL     out  $clog2(STACK_DEPTH+1)  entries currently on return stack
// HALTED          out  1        sequencer stopped; sticky until reset
// FAULT           out  2        bit0 stack overflow, bit1 stack underflow; sticky
// BEHAVIOUR
// - Reset (async, RST_N=0): state BOOT, PC=RESET_VECTOR, PC_LAST=RESET_VECTOR,
//   PC_VALID=0, REDIRECT=0, STACK_LEVEL=0, HALTED=0, FAULT=0. Deassert is sync'd.
// - States: BOOT -> RUN (1 cycle, unconditional); RUN; FLUSH; HALT.
// - RUN, STALL=1: no register changes; REDIRECT forced 0; input ignored.
// - RUN, STALL=0: PC_LAST<=PC. Instruction acted on only if INSTR_VALID=1.
//   * taken = FLAGS_ARE_VALID & kind in {JUMP,CALL,RET,HALT}.
//   * SEQ, or not taken, or INSTR_VALID=0: PC<=PC+1 (wraps max->0).
//   * JUMP taken: PC<=INSTR_TARGET, REDIRECT=1 next cycle, state FLUSH.
//   * CALL taken: push PC_LAST+1 (wrapping), PC<=INSTR_TARGET, REDIRECT, FLUSH.
//     Stack full: no push, FAULT[0]<=1, state HALT.
//   * RET taken: PC<=pop, REDIRECT, FLUSH. Stack empty: FAULT[1]<=1, HALT.
//   * HALT taken: state HALT, PC unchanged.
// - FLUSH: exactly one cycle, PC_VALID=0, incoming instruction discarded
//   (wrong path), PC held; returns to RUN regardless of STALL.
// - HALT: PC_VALID=0, HALTED=1, PC/stack frozen; exit only via reset.
// - PC_VALID=1 only in RUN. REDIRECT is registered, high exactly one cycle.
// - Push and pop never occur in the same cycle (one instruction per cycle).
// - Jump to own address is legal (tight loop), still flushes one cycle.
// - Reset mid-FLUSH/HALT: immediate return to reset values; stack contents
//   need not be cleared, only STACK_LEVEL.
// STRUCTURE
// - cpu_pkg: INSTR_KIND localparams (KIND_SEQ..KIND_HALT), sequencer state
//   encoding, FAULT bit indices; shared with decoder and flag validator bench.
// - Sub-module return_stack: LIFO with push/pop/full/empty/level, same
//   CLK/RST_N; overflow/underflow detection stays in branch_sequencer.
// TESTING
// - Reset, 4 cycles of SEQ, no stall -> PC 0,0(BOOT),1,2,3; PC_VALID 0,1,1,1.
// - JUMP target 0x40 with FLAGS_ARE_VALID=1 -> REDIRECT pulse, one PC_VALID=0
//   cycle, then PC=0x40,0x41; with FLAGS_ARE_VALID=0 -> PC+1, no REDIRECT.
// - CALL 0x80 at PC_LAST=0x10, then RET at 0x85 -> PC returns 0x11,
//   STACK_LEVEL 0->1->0.
// - 9 nested CALLs with STACK_DEPTH=8 -> ninth sets FAULT=2'b01, HALTED=1;
//   RET on empty stack after reset -> FAULT=2'b10, HALTED=1.
// - STALL=1 for 3 cycles during taken JUMP presentation -> PC, stack frozen,
//   no REDIRECT until STALL=0, then redirect exactly once.
// - PC=0xFF SEQ -> PC=0x00; RST_N pulsed low mid-FLUSH -> PC=RESET_VECTOR async.

Source files
------------

// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the PC sequencer: instruction kinds, FSM states, fault bits.
package branch_sequencer_pkg;

  localparam logic [2:0] KIND_SEQ  = 3'd0;
  localparam logic [2:0] KIND_JUMP = 3'd1;
  localparam logic [2:0] KIND_CALL = 3'd2;
  localparam logic [2:0] KIND_RET  = 3'd3;
  localparam logic [2:0] KIND_HALT = 3'd4;

  localparam int FAULT_OVF = 0;
  localparam int FAULT_UNF = 1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  // Kinds that may leave the sequential path when their condition passes.
  function automatic logic is_ctrl_kind(input logic [2:0] kind);
    return (kind == KIND_JUMP) || (kind == KIND_CALL) ||
           (kind == KIND_RET)  || (kind == KIND_HALT);
  endfunction

endpackage

// File: rtl/branch_sequencer_return_stack.sv
// LIFO of return addresses; ignores push when full and pop when empty.
module branch_sequencer_return_stack #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  top_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  localparam int IW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [LW-1:0] level_q, level_d;
  logic [IW-1:0] wr_idx, rd_idx;

  always_comb begin
    full_o  = (level_q == LW'(DEPTH));
    empty_o = (level_q == '0);
    wr_idx  = IW'(level_q);
    rd_idx  = IW'(level_q - LW'(1));
    top_o   = mem_q[rd_idx];
    level_d = level_q;
    if (push_i && !full_o)       level_d = level_q + LW'(1);
    else if (pop_i && !empty_o)  level_d = level_q - LW'(1);
  end

  // Entries are not reset; only the level matters for validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_idx] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) level_q <= '0;
    else          level_q <= level_d;
  end

  assign level_o = level_q;

endmodule

// File: rtl/branch_sequencer.sv
// Next-PC sequencer: sequential, conditional JUMP, CALL/RET via return stack, HALT.
// Every taken redirect squashes exactly one wrong-path instruction (FLUSH state).
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter  int                ADDR_W       = 8,
  parameter  int                STACK_DEPTH  = 8,
  parameter  logic [ADDR_W-1:0] RESET_VECTOR = '0,
  localparam int                LVL_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              instr_valid_i,
  input  logic [2:0]        instr_kind_i,
  input  logic [ADDR_W-1:0] instr_target_i,
  input  logic              flags_are_valid_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              redirect_o,
  output logic [LVL_W-1:0]  stack_level_o,
  output logic              halted_o,
  output logic [1:0]        fault_o
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] pc_q, pc_last_q;
  logic              pc_valid_q, redirect_q, halted_q;
  logic [1:0]        fault_q;

  logic              take, push_en, pop_en;
  logic [ADDR_W-1:0] ret_addr_d, pc_inc, stk_top;
  logic              stk_full, stk_empty;

  always_comb begin
    take       = (state_q == ST_RUN) && !stall_i && instr_valid_i &&
                 flags_are_valid_i && is_ctrl_kind(instr_kind_i);
    push_en    = take && (instr_kind_i == KIND_CALL) && !stk_full;
    pop_en     = take && (instr_kind_i == KIND_RET)  && !stk_empty;
    ret_addr_d = pc_last_q + ADDR_W'(1);
    pc_inc     = pc_q + ADDR_W'(1);
  end

  branch_sequencer_return_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_en),
    .pop_i   (pop_en),
    .data_i  (ret_addr_d),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .level_o (stack_level_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      pc_last_q  <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      redirect_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 2'b00;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (!stall_i) begin
            pc_last_q  <= pc_q;
            redirect_q <= 1'b0;
            pc_q       <= pc_inc;
            if (take) begin
              case (instr_kind_i)
                KIND_JUMP: begin
                  pc_q       <= instr_target_i;
                  redirect_q <= 1'b1;
                  pc_valid_q <= 1'b0;
                  state_q    <= ST_FLUSH;
                end
                KIND_CALL: begin
                  pc_valid_q <= 1'b0;
                  if (stk_full) begin
                    pc_q               <= pc_q;
                    fault_q[FAULT_OVF] <= 1'b1;
                    halted_q           <= 1'b1;
                    state_q            <= ST_HALT;
                  end else begin
                    pc_q       <= instr_target_i;
                    redirect_q <= 1'b1;
                    state_q    <= ST_FLUSH;
                  end
                end
                KIND_RET: begin
                  pc_valid_q <= 1'b0;
                  if (stk_empty) begin
                    pc_q               <= pc_q;
                    fault_q[FAULT_UNF] <= 1'b1;
                    halted_q           <= 1'b1;
                    state_q            <= ST_HALT;
                  end else begin
                    pc_q       <= stk_top;
                    redirect_q <= 1'b1;
                    state_q    <= ST_FLUSH;
                  end
                end
                default: begin
                  // Only KIND_HALT reaches here: take excludes SEQ and 5-7.
                  pc_q       <= pc_q;
                  pc_valid_q <= 1'b0;
                  halted_q   <= 1'b1;
                  state_q    <= ST_HALT;
                end
              endcase
            end
          end
        end
        ST_FLUSH: begin
          // Wrong-path instruction is dropped; stall does not extend the flush.
          redirect_q <= 1'b0;
          pc_valid_q <= 1'b1;
          state_q    <= ST_RUN;
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = pc_valid_q;
  assign redirect_o = redirect_q;
  assign halted_o   = halted_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed + random bench for branch_sequencer against a queue-based reference model.
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  localparam int AW = 8;
  localparam int SD = 8;
  localparam int LW = $clog2(SD + 1);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          stall = 1'b0, iv = 1'b0, fav = 1'b0;
  logic [2:0]    kind = 3'd0;
  logic [AW-1:0] tgt = '0;
  logic [AW-1:0] pc;
  logic          pc_valid, redirect, halted;
  logic [LW-1:0] level;
  logic [1:0]    fault;

  branch_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_VECTOR(8'h00)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .instr_valid_i(iv),
    .instr_kind_i(kind), .instr_target_i(tgt), .flags_are_valid_i(fav),
    .pc_o(pc), .pc_valid_o(pc_valid), .redirect_o(redirect),
    .stack_level_o(level), .halted_o(halted), .fault_o(fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: program-level view of the sequencer.
  int m_pc, m_last;
  bit m_boot, m_flush, m_halt, m_redir;
  bit [1:0] m_fault;
  int stk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_last = 0; m_boot = 1; m_flush = 0; m_halt = 0;
    m_redir = 0; m_fault = 0; stk.delete();
  endtask

  task automatic model_edge();
    int old;
    m_redir = 0;
    if (m_halt) return;
    if (m_boot)  begin m_boot = 0;  return; end
    if (m_flush) begin m_flush = 0; return; end
    if (stall) return;
    old  = m_pc;
    m_pc = (m_pc + 1) % 256;
    if (iv && fav) begin
      if (kind == KIND_JUMP) begin
        m_pc = int'(tgt); m_redir = 1; m_flush = 1;
      end else if (kind == KIND_CALL) begin
        if (stk.size() == SD) begin m_fault[0] = 1; m_halt = 1; m_pc = old; end
        else begin stk.push_back((m_last + 1) % 256); m_pc = int'(tgt); m_redir = 1; m_flush = 1; end
      end else if (kind == KIND_RET) begin
        if (stk.size() == 0) begin m_fault[1] = 1; m_halt = 1; m_pc = old; end
        else begin m_pc = stk.pop_back(); m_redir = 1; m_flush = 1; end
      end else if (kind == KIND_HALT) begin
        m_halt = 1; m_pc = old;
      end
    end
    m_last = old;
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".pc"},       32'(pc),       32'(m_pc));
    chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(!(m_boot || m_flush || m_halt)));
    chk({tag, ".redirect"}, 32'(redirect), 32'(m_redir));
    chk({tag, ".level"},    32'(level),    32'(stk.size()));
    chk({tag, ".halted"},   32'(halted),   32'(m_halt));
    chk({tag, ".fault"},    32'(fault),    32'(m_fault));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    cmp_all(tag);
  endtask

  task automatic drive(input logic [2:0] k, input logic [7:0] t, input bit v, input bit f, input bit s);
    kind = k; tgt = t; iv = v; fav = f; stall = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    chk("reset_pc_const", 32'(pc), 32'h0);
    chk("reset_valid_const", 32'(pc_valid), 32'h0);

    // Sequential fetch out of BOOT
    drive(KIND_SEQ, 8'h00, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc("seq");
    chk("seq_pc3", 32'(pc), 32'h3);

    // Taken and not-taken JUMP
    drive(KIND_JUMP, 8'h40, 1, 1, 0); cyc("jmp_take");
    chk("jmp_redirect", 32'(redirect), 32'h1);
    drive(KIND_SEQ, 8'h00, 1, 0, 0);  cyc("jmp_flush_done");
    chk("jmp_pc40", 32'(pc), 32'h40);
    cyc("jmp_next");
    chk("jmp_pc41", 32'(pc), 32'h41);
    drive(KIND_JUMP, 8'h20, 1, 0, 0); cyc("jmp_not_taken");
    chk("jmp_nt_pc", 32'(pc), 32'h42);

    // CALL from PC_LAST=0x10, RET from 0x85
    drive(KIND_JUMP, 8'h10, 1, 1, 0); cyc("to10");
    drive(KIND_SEQ, 8'h00, 0, 0, 0);  cyc("to10_flush");
    cyc("to10_run");
    drive(KIND_CALL, 8'h80, 1, 1, 0); cyc("call");
    chk("call_level1", 32'(level), 32'h1);
    drive(KIND_SEQ, 8'h00, 1, 0, 0);
    for (int i = 0; i < 20 && m_last != 8'h85; i++) cyc("walk");
    chk("walk_reached_85", 32'(m_last), 32'h85);
    drive(KIND_RET, 8'h00, 1, 1, 0);  cyc("ret");
    chk("ret_pc11", 32'(pc), 32'h11);
    chk("ret_level0", 32'(level), 32'h0);
    drive(KIND_SEQ, 8'h00, 1, 0, 0);  cyc("ret_flush");

    // Stall over a taken JUMP
    drive(KIND_JUMP, 8'h55, 1, 1, 1);
    for (int i = 0; i < 3; i++) cyc("stall");
    chk("stall_no_redirect", 32'(redirect), 32'h0);
    drive(KIND_JUMP, 8'h55, 1, 1, 0); cyc("stall_release");
    chk("stall_redirect", 32'(redirect), 32'h1);
    drive(KIND_SEQ, 8'h00, 1, 0, 1);  cyc("stall_flush");
    chk("redirect_once", 32'(redirect), 32'h0);
    drive(KIND_SEQ, 8'h00, 1, 0, 0);

    // PC wrap 0xFF -> 0x00
    drive(KIND_JUMP, 8'hFF, 1, 1, 0); cyc("toFF");
    drive(KIND_SEQ, 8'h00, 1, 0, 0);  cyc("toFF_flush");
    cyc("wrap");
    chk("wrap_pc00", 32'(pc), 32'h0);

    // Async reset in the middle of FLUSH
    drive(KIND_JUMP, 8'h33, 1, 1, 0); cyc("pre_rst_flush");
    #2;
    do_reset();
    drive(KIND_SEQ, 8'h00, 1, 0, 0);  cyc("post_rst");

    // Overflow on the ninth nested CALL
    do_reset();
    cyc("ovf_boot");
    for (int i = 0; i < 9; i++) begin
      drive(KIND_CALL, 8'(8'h20 + i), 1, 1, 0); cyc("ovf_call");
      drive(KIND_SEQ, 8'h00, 0, 0, 0);          cyc("ovf_gap");
    end
    chk("ovf_fault", 32'(fault), 32'h1);
    chk("ovf_halted", 32'(halted), 32'h1);

    // Underflow on RET right after reset
    do_reset();
    cyc("unf_boot");
    drive(KIND_RET, 8'h00, 1, 1, 0); cyc("unf_ret");
    chk("unf_fault", 32'(fault), 32'h2);
    chk("unf_halted", 32'(halted), 32'h1);

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
      drive(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 9) < 8,
            $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
